switch_debounce_array: RTL and testbench

SWITCH_DEBOUNCE_ARRAY -- requirements
Module: switch_debounce_array

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 79 +++++++
 rtl/switch_debounce_array.sv | 38 +++
 tb/tb_switch_debounce_array.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the switch debounce array.
package debounce_pkg;

   localparam int DEF_NUM_CHANNELS   = 4;
   localparam int DEF_DEBOUNCE_DELAY = 16;
   localparam int DEF_SYNC_STAGES    = 2;

   // Width needed to hold counts 0..delay inclusive.
   function automatic int cnt_width(input int delay);
      return (delay < 1) ? 1 : $clog2(delay + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchronizer chain, agreement counter, stable bit and optional edge strobes.
// Edge strobes exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_DELAY = DEF_DEBOUNCE_DELAY,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic stable_out
`ifdef DEBOUNCE_EDGE_PULSE_EN
   ,
   output logic rise_out,
   output logic fall_out
`endif
);

   localparam int CW = cnt_width(DEBOUNCE_DELAY);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_DELAY - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync_bit;
   logic                   flip;

   assign sync_bit = sync_q[SYNC_STAGES-1];
   // The edge that would bring the count to DEBOUNCE_DELAY flips the level instead.
   assign flip     = (sync_bit != stable_q) && (cnt_q == CNT_LAST);

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_bit != stable_q) begin
         if (flip) stable_d = ~stable_q;
         else      cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_out = stable_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic rise_q, rise_d, fall_q, fall_d;

   always_comb begin
      rise_d = flip & ~stable_q;
      fall_d = flip &  stable_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_out = rise_q;
   assign fall_out = fall_q;
`endif

endmodule

// File: rtl/switch_debounce_array.sv
// Array of independent switch debouncers, one debounce_channel per pin.
// Define DEBOUNCE_EDGE_PULSE_EN to add the rise_pulse/fall_pulse strobe ports.
module switch_debounce_array
   import debounce_pkg::*;
#(
   parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
   parameter int DEBOUNCE_DELAY = DEF_DEBOUNCE_DELAY,
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] raw_input,
   output logic [NUM_CHANNELS-1:0] debounced_value
`ifdef DEBOUNCE_EDGE_PULSE_EN
   ,
   output logic [NUM_CHANNELS-1:0] rise_pulse,
   output logic [NUM_CHANNELS-1:0] fall_pulse
`endif
);

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_DELAY (DEBOUNCE_DELAY),
         .SYNC_STAGES    (SYNC_STAGES)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .raw_in     (raw_input[g]),
         .stable_out (debounced_value[g])
`ifdef DEBOUNCE_EDGE_PULSE_EN
         ,
         .rise_out   (rise_pulse[g]),
         .fall_out   (fall_pulse[g])
`endif
      );
   end

endmodule

// File: tb/tb_switch_debounce_array.sv
// Directed bench for switch_debounce_array (4 channels, delay 8, 2 sync stages).
// Strobe checks compile in only when DEBOUNCE_EDGE_PULSE_EN is defined.
module tb_switch_debounce_array;

   localparam int NC = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NC-1:0] raw_input;
   logic [NC-1:0] debounced_value;
`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic [NC-1:0] rise_pulse, fall_pulse;
`endif

   int tests = 0;
   int fails = 0;

   switch_debounce_array #(
      .NUM_CHANNELS   (NC),
      .DEBOUNCE_DELAY (8),
      .SYNC_STAGES    (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .raw_input       (raw_input),
      .debounced_value (debounced_value)
`ifdef DEBOUNCE_EDGE_PULSE_EN
      ,
      .rise_pulse      (rise_pulse),
      .fall_pulse      (fall_pulse)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_pulses(input string tag, input logic [NC-1:0] r, input logic [NC-1:0] f);
`ifdef DEBOUNCE_EDGE_PULSE_EN
      check({tag, "_rise"}, rise_pulse, r);
      check({tag, "_fall"}, fall_pulse, f);
`else
      if (r === f) ; // strobes absent in this build
`endif
   endtask

   initial begin
      reset     = 1'b1;
      raw_input = '0;
      tick(3);
      check("reset_dv", debounced_value, 4'b0000);
      check_pulses("reset", 4'b0000, 4'b0000);
      reset = 1'b0;
      tick(2);

      // Ch0 press: new level sampled from edge 1, output flips on edge 10
      raw_input[0] = 1'b1;
      tick(9);
      check("ch0_e9", debounced_value, 4'b0000);
      tick(1);
      check("ch0_e10", debounced_value, 4'b0001);
      check_pulses("ch0_e10", 4'b0001, 4'b0000);
      tick(1);
      check("ch0_e11", debounced_value, 4'b0001);
      check_pulses("ch0_e11", 4'b0000, 4'b0000);

      // Ch1 glitch: 5 high, 1 low, then high; count restarts from the final rise
      raw_input[1] = 1'b1;
      tick(5);
      raw_input[1] = 1'b0;
      tick(1);
      raw_input[1] = 1'b1;
      tick(9);
      check("ch1_glitch_e9", debounced_value, 4'b0001);
      check_pulses("ch1_glitch_e9", 4'b0000, 4'b0000);
      tick(1);
      check("ch1_e10", debounced_value, 4'b0011);
      check_pulses("ch1_e10", 4'b0010, 4'b0000);

      // Ch2 up, then release
      raw_input[2] = 1'b1;
      tick(10);
      check("ch2_up", debounced_value, 4'b0111);
      tick(1);
      raw_input[2] = 1'b0;
      tick(9);
      check("ch2_fall_e9", debounced_value, 4'b0111);
      tick(1);
      check("ch2_fall_e10", debounced_value, 4'b0011);
      check_pulses("ch2_fall_e10", 4'b0000, 4'b0100);
      tick(1);
      check_pulses("ch2_fall_e11", 4'b0000, 4'b0000);

      // All four channels toggle on the same edge
      raw_input = 4'b1100;
      tick(9);
      check("all_e9", debounced_value, 4'b0011);
      tick(1);
      check("all_e10", debounced_value, 4'b1100);
      check_pulses("all_e10", 4'b1100, 4'b0011);
      tick(1);
      check_pulses("all_e11", 4'b0000, 4'b0000);

      // Reset mid-count (count 5 on ch0/ch1), asserted between edges
      raw_input = 4'b1111;
      tick(7);
      check("pre_rst", debounced_value, 4'b1100);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_dv", debounced_value, 4'b0000);
      check_pulses("async_rst", 4'b0000, 4'b0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick(1);
      check_pulses("post_rst_e1", 4'b0000, 4'b0000);
      tick(8);
      check("post_rst_e9", debounced_value, 4'b0000);
      tick(1);
      check("post_rst_e10", debounced_value, 4'b1111);
      check_pulses("post_rst_e10", 4'b1111, 4'b0000);
      tick(1);
      check("post_rst_e11", debounced_value, 4'b1111);
      check_pulses("post_rst_e11", 4'b0000, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
